aes_inv_key_schedule: RTL and testbench
=======================================

Name: aes_inv_key_schedule

Overview:
- Iterative AES-128 inverse key schedule for the decryption datapath. It is the reverse direction of KeyExpansion.
- Takes the last round key (rk10) and streams round keys 10, 9, …, 0 over a valid/ready interface, one per handshake.
- The round-key consumer is the AES-128 inverse cipher.
- The decryption core then needs only the rk10 value supplied at start, rather than all eleven round keys stored in parallel.

Parameters:
- None. AES-128 only: 4-word key, 10 rounds.

Ports:
- clk  input  1  system clock, rising-edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request to begin a schedule; sampled only when idle
- key_last  input  128  round-10 key, captured on an accepted start; word w[40] = bits 127:96
- rk_ready  input  1  consumer accepts rk_out this cycle
- rk_valid  output  1  rk_out/rk_round are valid
- rk_out  output  128  current round key
- rk_round  output  4  round index of rk_out (10 down to 0)
- busy  output  1  schedule in progress
- done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (async, reset_n=0): state=IDLE, key_reg=0, round=0, rk_valid=0, rk_out=0, rk_round=0, busy=0, done=0. Reset mid-stream aborts immediately; no further outputs are produced.
- States:
  - IDLE (rk_valid=0, busy=0).
  - STREAM (rk_valid=1, busy=1).
- IDLE: if start=1 at a clock edge, key_reg<=key_last, round<=10, go to STREAM.
- STREAM: rk_out=key_reg and rk_round=round, both registered.
  - On rk_valid&rk_ready:
    - If round==0: go to IDLE and set done=1 for the next cycle only.
    - Otherwise: key_reg<=inv_step(key_reg, Rcon[round]) and round<=round-1.
  - While rk_ready=0: rk_out and rk_round are held stable; no state change.
- Latency:
  - rk_valid rises the cycle after start is accepted, with round 10.
  - With rk_ready held at 1: rounds 10..0 appear on 11 consecutive cycles, done pulses on cycle 12, and busy is high for exactly 11 cycles.
- start while busy=1 is ignored, with no effect on key_reg or round.
- start in the done cycle (state IDLE) is accepted normally; back-to-back schedules have exactly one idle cycle between them.
- rk_out outside STREAM holds the last key_reg value; the bench must not check it when rk_valid=0.
- inv_step: input words a0..a3 (a0 = bits 127:96); output words b0..b3, computed combinationally in one cycle.
  - b3 = a3^a2
  - b2 = a2^a1
  - b1 = a1^a0
  - b0 = a0 ^ SubWord(RotWord(b3)) ^ {Rcon[r], 24'h0}
- RotWord({x0,x1,x2,x3}) = {x1,x2,x3,x0}.
- SubWord: four forward AES S-box byte lookups, not the inverse S-box; the lookups are purely combinational.
- Rcon[r], r=1..10: 01,02,04,08,10,20,40,80,1B,36. The value applied when deriving round r-1 from round r is Rcon[r].
- All XOR operations are bitwise with no carries; round counter underflow below 0 cannot occur.

Test Plan:
- Directed stream, rk_ready=1:
  - Stimulus: reset, then start with key_last=28FDDEF86DA4244ACCC0A4FE3B316F26.
  - Required sequence:
    - rk9=BFE2BF904559FAB2A16480B4F7F1CBD8
    - rk8=8E51EF21FABB4522E43D7A0656954B6C
    - rk5=B1293B3305418592D210D232C6429B69
    - rk1=E232FCF191129188B159E4E6D679A293
    - rk0=5468617473206D79204B756E67204675
  - rk_round must read 10..0 on 11 consecutive cycles, then done=1 for one cycle with busy=0.
- FIPS-197 vector:
  - Stimulus: key_last=D014F9A8C9EE2589E13F0CC8B6630CA6.
  - Required: round 0 is 2B7E151628AED2A6ABF7158809CF4F3C, and done pulses exactly once.
- Backpressure:
  - Stimulus: drive rk_ready with a pseudo-random pattern, including 5 consecutive low cycles while round=6.
  - Required: rk_out/rk_round are stable while rk_ready=0, the full 11-key sequence is unchanged, and no round is skipped or duplicated.
- Start while busy:
  - Stimulus: pulse start with a different key_last at round 7.
  - Required: ignored; the sequence continues to the correct rk0 of the first key.
- Back-to-back:
  - Stimulus: assert start during the done cycle with the FIPS key.
  - Required: the second schedule begins the following cycle and produces the correct keys.
- Reset mid-operation:
  - Stimulus: drive reset_n low asynchronously, mid-cycle, at round 4.
  - Required: rk_valid/busy/done/rk_round/rk_out go to 0 immediately. After release, the block stays IDLE until start, and a new start produces the full correct sequence.

Source files
------------

// File: rtl/aes_inv_key_schedule.sv
// Iterative AES-128 inverse key schedule: loads round key 10 and streams
// round keys 10 down to 0 over a valid/ready handshake, one key per transfer.
module aes_inv_key_schedule (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] key_last,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    // Forward AES S-box; byte 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {x, 3'b000};
        return SBOX_TABLE[11'd2047 - idx -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Derives round key r-1 from round key r; the three XOR-chained words are
    // undone first because the first word depends on the recovered last word.
    function automatic logic [127:0] inv_step(input logic [127:0] a, input logic [3:0] r);
        logic [31:0] a0, a1, a2, a3;
        logic [31:0] b0, b1, b2, b3;
        a0 = a[127:96];
        a1 = a[95:64];
        a2 = a[63:32];
        a3 = a[31:0];
        b3 = a3 ^ a2;
        b2 = a2 ^ a1;
        b1 = a1 ^ a0;
        b0 = a0 ^ sub_word({b3[23:0], b3[31:24]}) ^ {rcon(r), 24'h000000};
        return {b0, b1, b2, b3};
    endfunction

    state_t       state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_last;
                    round_d = 4'd10;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (valid_q && rk_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = inv_step(key_q, round_q);
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == STREAM);
        busy_d  = (state_d == STREAM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = valid_q;
    assign rk_out   = key_q;
    assign rk_round = round_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule: table vectors, directed corner
// sequences and random keys with backpressure against a word-level key model.
module tb_aes_inv_key_schedule;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [127:0] key_last;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sbox_m   [256];
    logic [7:0]   rcon_m   [11];
    logic [127:0] model_rk [11];
    logic [127:0] captured [11];

    typedef struct {
        logic [127:0] key;
        int           round;
        logic [127:0] expected;
    } vec_t;

    vec_t vecs [6];

    localparam logic [127:0] KEY_A   = 128'h28FDDEF86DA4244ACCC0A4FE3B316F26;
    localparam logic [127:0] KEY_A0  = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] KEY_F   = 128'hD014F9A8C9EE2589E13F0CC8B6630CA6;
    localparam logic [127:0] KEY_F0  = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

    aes_inv_key_schedule dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .key_last (key_last),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference S-box built from GF(2^8) inversion plus the affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gf_mul(x[7:0], y[7:0]) == 8'h01) begin
                        inv = y[7:0];
                        break;
                    end
                end
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc = 8'h01;
        rcon_m[0] = 8'h00;
        for (int r = 1; r <= 10; r++) begin
            rcon_m[r] = rc;
            rc = gf_mul(rc, 8'h02);
        end
    endtask

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // Run the KeyExpansion word recurrence backwards from w[40..43].
    task automatic build_model(input logic [127:0] k10);
        logic [31:0] w [44];
        logic [31:0] t;
        w[40] = k10[127:96];
        w[41] = k10[95:64];
        w[42] = k10[63:32];
        w[43] = k10[31:0];
        for (int i = 43; i >= 4; i--) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_word_m({t[23:0], t[31:24]}) ^ {rcon_m[i/4], 24'h000000};
            w[i-4] = w[i] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [127:0] key);
        start    = 1'b1;
        key_last = key;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Called at the negedge where round 10 should be visible.
    task automatic stream(input logic [127:0] key, input int mode, input int inject_round,
                          input int abort_round, input logic [127:0] other_key);
        int   expect_r;
        int   cycles;
        int   low_run;
        bit   rdy;
        bit   aborted;
        build_model(key);
        expect_r = 10;
        cycles   = 0;
        low_run  = 0;
        aborted  = 1'b0;
        while (expect_r >= 0 && cycles < 300) begin
            checkOutput("rk_valid", rk_valid, 1);
            checkOutput("busy", busy, 1);
            checkOutput("done_low", done, 0);
            checkOutput("rk_round", rk_round, expect_r);
            checkOutput("rk_out", rk_out, model_rk[expect_r]);
            if (abort_round == expect_r) begin
                #2 reset_n = 1'b0;
                #1;
                checkOutput("abort_valid", rk_valid, 0);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_done", done, 0);
                checkOutput("abort_round", rk_round, 0);
                checkOutput("abort_out", rk_out, 0);
                aborted = 1'b1;
                break;
            end
            if (mode == 0) begin
                rdy = 1'b1;
            end else if (expect_r == 6 && low_run < 5) begin
                rdy = 1'b0;
                low_run++;
            end else begin
                rdy = ($urandom_range(0, 2) != 0);
            end
            rk_ready = rdy;
            start    = (expect_r == inject_round);
            if (start) key_last = other_key;
            if (rdy) captured[expect_r] = rk_out;
            @(negedge clk);
            cycles++;
            if (rdy) expect_r--;
        end
        start = 1'b0;
        if (!aborted) begin
            if (cycles >= 300) checkOutput("stream_timeout", cycles, 0);
            if (mode == 0) checkOutput("cycle_count", cycles, 11);
        end
    endtask

    task automatic finish_sched(input bit chain, input logic [127:0] chain_key);
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_in_done", busy, 0);
        checkOutput("valid_in_done", rk_valid, 0);
        if (chain) begin
            applyStimulus(chain_key);
        end else begin
            @(negedge clk);
            checkOutput("done_cleared", done, 0);
            checkOutput("idle_valid", rk_valid, 0);
        end
    endtask

    initial begin
        logic [127:0] rkey;
        reset_n  = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        key_last = '0;
        build_tables();

        vecs[0] = '{KEY_A, 9, 128'hBFE2BF904559FAB2A16480B4F7F1CBD8};
        vecs[1] = '{KEY_A, 8, 128'h8E51EF21FABB4522E43D7A0656954B6C};
        vecs[2] = '{KEY_A, 5, 128'hB1293B3305418592D210D232C6429B69};
        vecs[3] = '{KEY_A, 1, 128'hE232FCF191129188B159E4E6D679A293};
        vecs[4] = '{KEY_A, 0, KEY_A0};
        vecs[5] = '{KEY_F, 0, KEY_F0};

        #3;
        checkOutput("reset_valid", rk_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_round", rk_round, 0);
        checkOutput("reset_out", rk_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_after_reset", rk_valid, 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].key);
            stream(vecs[i].key, 0, -1, -1, '0);
            checkOutput("table_key", captured[vecs[i].round], vecs[i].expected);
            finish_sched(1'b0, '0);
        end

        // Backpressure with a forced five-cycle stall at round 6.
        applyStimulus(KEY_A);
        stream(KEY_A, 1, -1, -1, '0);
        checkOutput("bp_rk0", captured[0], KEY_A0);
        finish_sched(1'b0, '0);

        // Start pulsed with another key while streaming round 7.
        applyStimulus(KEY_A);
        stream(KEY_A, 0, 7, -1, KEY_F);
        checkOutput("busy_start_rk0", captured[0], KEY_A0);
        finish_sched(1'b0, '0);

        // Back-to-back schedules chained through the done cycle.
        applyStimulus(KEY_A);
        stream(KEY_A, 0, -1, -1, '0);
        finish_sched(1'b1, KEY_F);
        stream(KEY_F, 0, -1, -1, '0);
        checkOutput("b2b_rk0", captured[0], KEY_F0);
        finish_sched(1'b0, '0);

        // Asynchronous reset at round 4, then recovery.
        applyStimulus(KEY_A);
        stream(KEY_A, 0, -1, 4, '0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("post_reset_valid", rk_valid, 0);
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_done", done, 0);
        applyStimulus(KEY_F);
        stream(KEY_F, 0, -1, -1, '0);
        checkOutput("post_reset_rk0", captured[0], KEY_F0);
        finish_sched(1'b0, '0);

        for (int n = 0; n < 6; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(rkey);
            stream(rkey, 1, -1, -1, '0);
            finish_sched(1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
